portal_pipe_mux: RTL and testbench

Parametrised N-channel message-pipe multiplexer for the portal transport layer. It takes NUM_CHANNELS independent request/indication pipes, each DATA_WIDTH bits wide, buffers each in a private FIFO, and arbitrates them onto one tagged outbound pipe. It sits between the per-interface serialisers (request/indication output stages) and the shared host link. It generalises the fixed single-pipe 96-bit wiring to a configurable width, depth and channel count, with selectable arbitration and per-channel enables.

---
 rtl/portal_pipe_mux.sv | 140 ++++++++++++++
 tb/tb_portal_pipe_mux.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/portal_pipe_mux.sv
// N-channel message-pipe multiplexer: per-channel circular FIFOs arbitrated
// (round-robin or fixed priority) onto one tagged, registered outbound pipe.

module portal_pipe_fifo #(
    parameter int DATA_WIDTH = 96,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
endmodule

module portal_pipe_mux #(
    parameter int DATA_WIDTH   = 96,
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 4,
    parameter int ARB_MODE     = 0,
    localparam int TAG_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    input  logic [NUM_CHANNELS-1:0]            chan_enable,
    output logic                               out_valid,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [TAG_WIDTH-1:0]               out_tag,
    input  logic                               out_ready,
    output logic [NUM_CHANNELS-1:0]            fifo_empty
);
    logic [NUM_CHANNELS-1:0]                 full, empty, push, pop, cand;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] head;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [TAG_WIDTH-1:0]  out_tag_q;
    logic [TAG_WIDTH-1:0]  last_grant_q;

    logic                  load_en;
    logic                  grant_vld;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [TAG_WIDTH-1:0]  sel;
    int                    idx;

    // Ready comes only from registered occupancy and is held low during reset.
    assign in_ready   = ~full & {NUM_CHANNELS{~RST}};
    assign push       = in_valid & in_ready;
    assign cand       = ~empty & chan_enable;
    assign fifo_empty = empty;

    genvar i;
    generate
        for (i = 0; i < NUM_CHANNELS; i++) begin : g_chan
            portal_pipe_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_fifo (
                .CLK     (CLK),
                .RST     (RST),
                .push_i  (push[i]),
                .data_i  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
                .pop_i   (pop[i]),
                .head_o  (head[i]),
                .full_o  (full[i]),
                .empty_o (empty[i])
            );
            assign pop[i] = load_en & grant_vld & (grant_idx == TAG_WIDTH'(i));
        end
    endgenerate

    assign load_en = !out_valid_q || out_ready;

    // Scan from farthest to nearest so the nearest candidate is the last hit.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        sel       = '0;
        for (int k = NUM_CHANNELS; k >= 1; k--) begin
            if (ARB_MODE == 1) idx = k - 1;
            else               idx = (int'(last_grant_q) + k) % NUM_CHANNELS;
            sel = TAG_WIDTH'(idx);
            if (cand[sel]) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            last_grant_q <= TAG_WIDTH'(NUM_CHANNELS - 1);
        end else if (load_en) begin
            out_valid_q <= grant_vld;
            if (grant_vld) begin
                out_data_q   <= head[grant_idx];
                out_tag_q    <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
endmodule

// File: tb/tb_portal_pipe_mux.sv
// Bench for portal_pipe_mux: a round-robin instance checked every cycle against
// a queue-based transaction model, plus a fixed-priority instance with directed checks.

module tb_portal_pipe_mux;
    localparam int DW = 96;
    localparam int NC = 4;
    localparam int DEPTH = 4;
    localparam int TW = 2;

    typedef logic [DW-1:0] word_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    // Round-robin instance
    logic [NC-1:0]    in_valid, in_ready, chan_enable, fifo_empty;
    logic [NC*DW-1:0] in_data;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [TW-1:0]    out_tag;

    // Fixed-priority instance
    logic [NC-1:0]    fp_in_valid, fp_in_ready, fp_chan_enable, fp_fifo_empty;
    logic [NC*DW-1:0] fp_in_data;
    logic             fp_out_valid, fp_out_ready;
    logic [DW-1:0]    fp_out_data;
    logic [TW-1:0]    fp_out_tag;

    portal_pipe_mux #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .DEPTH(DEPTH), .ARB_MODE(0)) dut_rr (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .chan_enable(chan_enable), .out_valid(out_valid), .out_data(out_data),
        .out_tag(out_tag), .out_ready(out_ready), .fifo_empty(fifo_empty));

    portal_pipe_mux #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .DEPTH(DEPTH), .ARB_MODE(1)) dut_fp (
        .CLK(CLK), .RST(RST), .in_valid(fp_in_valid), .in_data(fp_in_data), .in_ready(fp_in_ready),
        .chan_enable(fp_chan_enable), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_tag(fp_out_tag), .out_ready(fp_out_ready), .fifo_empty(fp_fifo_empty));

    int n_chk = 0;
    int n_err = 0;

    // Transaction model of the round-robin instance
    word_t mq [NC][$];
    logic  m_ov;
    word_t m_od;
    int    m_ot;
    int    m_lg;

    task automatic chk(string name, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) mq[c].delete();
        m_ov = 1'b0;
        m_od = '0;
        m_ot = 0;
        m_lg = NC - 1;
    endtask

    // Applies the rules for one rising edge using the inputs present at it.
    task automatic model_edge();
        bit acc [NC];
        int g;
        bit loadable;
        for (int c = 0; c < NC; c++) acc[c] = in_valid[c] && (mq[c].size() < DEPTH);
        loadable = !m_ov || out_ready;
        g = -1;
        if (loadable) begin
            for (int k = 1; k <= NC; k++) begin
                int c;
                c = (m_lg + k) % NC;
                if (g < 0 && mq[c].size() > 0 && chan_enable[c]) g = c;
            end
            if (g >= 0) begin
                m_od = mq[g].pop_front();
                m_ot = g;
                m_ov = 1'b1;
                m_lg = g;
            end else begin
                m_ov = 1'b0;
            end
        end
        for (int c = 0; c < NC; c++)
            if (acc[c]) mq[c].push_back(in_data[c*DW +: DW]);
    endtask

    task automatic check_all();
        logic [NC-1:0] exp_rdy, exp_emp;
        for (int c = 0; c < NC; c++) begin
            exp_rdy[c] = !RST && (mq[c].size() < DEPTH);
            exp_emp[c] = (mq[c].size() == 0);
        end
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("fifo_empty", 128'(fifo_empty), 128'(exp_emp));
        chk("out_valid", 128'(out_valid), 128'(m_ov));
        if (m_ov) begin
            chk("out_data", 128'(out_data), 128'(m_od));
            chk("out_tag", 128'(out_tag), 128'(m_ot));
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_valid = '0;
        fp_in_valid = '0;
        RST = 1'b1;
        model_clear();
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk("rst_out_tag", 128'(out_tag), 128'(0));
        chk("rst_fifo_empty", 128'(fifo_empty), 128'(4'hF));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_fp_out_valid", 128'(fp_out_valid), 128'(0));
        chk("rst_fp_fifo_empty", 128'(fp_fifo_empty), 128'(4'hF));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("rel_in_ready", 128'(in_ready), 128'(4'hF));
        chk("rel_fp_in_ready", 128'(fp_in_ready), 128'(4'hF));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = '0; in_data = '0; chan_enable = 4'hF; out_ready = 1'b1;
        fp_in_valid = '0; fp_in_data = '0; fp_chan_enable = 4'hF; fp_out_ready = 1'b1;
        model_clear();
        #1;
        do_reset();

        // Single message, 2-cycle latency, one-cycle pulse
        in_valid = 4'b0100;
        in_data[2*DW +: DW] = 96'h1234;
        tick();
        in_valid = '0;
        chk("single_c1_valid", 128'(out_valid), 128'(0));
        tick();
        chk("single_c2_valid", 128'(out_valid), 128'(1));
        chk("single_c2_data", 128'(out_data), 128'(96'h1234));
        chk("single_c2_tag", 128'(out_tag), 128'(2));
        tick();
        chk("single_c3_valid", 128'(out_valid), 128'(0));

        // Round-robin fairness
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NC; c++) in_data[c*DW +: DW] = DW'((c << 8) | k);
            tick();
        end
        in_valid = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            if (n > 0) tick();
            chk("rr_valid", 128'(out_valid), 128'(1));
            chk("rr_tag", 128'(out_tag), 128'(n % NC));
        end
        tick();
        chk("rr_done", 128'(out_valid), 128'(0));

        // Backpressure: 4 in the FIFO plus 1 in the output register
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b0010;
        for (int t = 0; t < 6; t++) begin
            in_data[1*DW +: DW] = DW'(32'hB000 + t);
            tick();
            if (t == 4) chk("bp_full", 128'(in_ready[1]), 128'(0));
        end
        in_valid = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) tick();
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_data", 128'(out_data), 128'(32'hB000 + n));
        end
        tick();
        chk("bp_done", 128'(out_valid), 128'(0));

        // Random traffic, stalls and enable mask against the model
        do_reset();
        for (int t = 0; t < 300; t++) begin
            in_valid = 4'($urandom);
            for (int w = 0; w < NC*DW/32; w++) in_data[w*32 +: 32] = $urandom;
            out_ready = 1'($urandom);
            chan_enable = 4'($urandom | $urandom);
            tick();
        end
        in_valid = '0;
        chan_enable = 4'hF;
        out_ready = 1'b1;
        for (int t = 0; t < 24; t++) tick();
        chk("rand_drained", 128'(fifo_empty), 128'(4'hF));

        // Mid-stream reset
        do_reset();
        out_ready = 1'b0;
        in_valid = 4'b0001;
        for (int t = 0; t < 4; t++) begin
            in_data[0 +: DW] = DW'(32'hC00 + t);
            tick();
        end
        in_valid = '0;
        chk("mid_pre_valid", 128'(out_valid), 128'(1));
        chk("mid_pre_empty", 128'(fifo_empty[0]), 128'(0));
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b1000;
        in_data[3*DW +: DW] = 96'hABC;
        tick();
        in_valid = '0;
        chk("mid_c1_valid", 128'(out_valid), 128'(0));
        tick();
        chk("mid_c2_valid", 128'(out_valid), 128'(1));
        chk("mid_c2_data", 128'(out_data), 128'(96'hABC));
        chk("mid_c2_tag", 128'(out_tag), 128'(3));
        tick();
        chk("mid_c3_valid", 128'(out_valid), 128'(0));

        // Fixed priority with enable mask
        do_reset();
        fp_out_ready = 1'b0;
        fp_chan_enable = 4'b1110;
        fp_in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            fp_in_data[0*DW +: DW] = DW'(32'hA0 + k);
            fp_in_data[3*DW +: DW] = DW'(32'hD0 + k);
            tick();
        end
        fp_in_valid = '0;
        fp_out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            if (n > 0) tick();
            chk("fp_c3_valid", 128'(fp_out_valid), 128'(1));
            chk("fp_c3_tag", 128'(fp_out_tag), 128'(3));
            chk("fp_c3_data", 128'(fp_out_data), 128'(32'hD0 + n));
        end
        tick();
        chk("fp_masked_idle0", 128'(fp_out_valid), 128'(0));
        tick();
        chk("fp_masked_idle1", 128'(fp_out_valid), 128'(0));
        chk("fp_masked_held", 128'(fp_fifo_empty), 128'(4'b1110));
        fp_chan_enable = 4'hF;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("fp_c0_valid", 128'(fp_out_valid), 128'(1));
            chk("fp_c0_tag", 128'(fp_out_tag), 128'(0));
            chk("fp_c0_data", 128'(fp_out_data), 128'(32'hA0 + n));
        end
        tick();
        chk("fp_c0_done", 128'(fp_out_valid), 128'(0));

        // Lowest index wins under fixed priority
        fp_out_ready = 1'b0;
        fp_in_valid = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            fp_in_data[1*DW +: DW] = DW'(32'h10 + k);
            fp_in_data[2*DW +: DW] = DW'(32'h20 + k);
            tick();
        end
        fp_in_valid = '0;
        fp_out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) tick();
            chk("fp_pri_valid", 128'(fp_out_valid), 128'(1));
            chk("fp_pri_tag", 128'(fp_out_tag), 128'(n < 2 ? 1 : 2));
            chk("fp_pri_data", 128'(fp_out_data), 128'(n < 2 ? 32'h10 + n : 32'h20 + n - 2));
        end
        tick();
        chk("fp_pri_done", 128'(fp_out_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
